// File: rtl/udp_cmd_pkg.sv
// udp_cmd_pkg: shared state encoding, command byte layout and opcodes for udp_cmd_rx
package udp_cmd_pkg;
   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
   localparam int IDX_OP   = 0;
   localparam int IDX_CH   = 1;
   localparam int IDX_DATA = 2;
   localparam int IDX_FLAG = 6;
   localparam int IDX_CHK  = 7;
   localparam int SH_BYTES = IDX_CHK;
   localparam logic [7:0] OP_START = 8'h64;
   localparam logic [7:0] OP_STOP  = 8'h65;
   localparam logic [7:0] OP_TRIG  = 8'h66;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: increment-by-one counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/udp_cmd_rx.sv
// udp_cmd_rx: parses fixed-length UDP command frames into a held command with valid/ready.
// Define UDP_CMD_CHKSUM_EN to require byte7 == XOR of bytes 0..6.
module udp_cmd_rx
   import udp_cmd_pkg::*;
#(
   parameter int P_CMD_LEN = 8,
   parameter int P_CNT_W   = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [15:0]        i_rec_len,
   input  logic [7:0]         i_rec_data,
   input  logic               i_rec_last,
   input  logic               i_rec_valid,
   output logic [7:0]         o_cmd_op,
   output logic [7:0]         o_cmd_ch,
   output logic [31:0]        o_cmd_data,
   output logic [7:0]         o_cmd_flag,
   output logic               o_cmd_valid,
   input  logic               i_cmd_ready,
   output logic [P_CNT_W-1:0] o_len_err_cnt,
   output logic [P_CNT_W-1:0] o_drop_cnt,
   output logic               o_busy
);
   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx, wr_idx;
   logic [7:0] sh [SH_BYTES];
   logic [7:0] sh_nx [SH_BYTES];
   logic       wr, complete, err_inc, drop_inc, load, chk_ok, len_ok, at_end;

   assign len_ok = i_rec_len == 16'(P_CMD_LEN);
   assign at_end = cnt == 8'(P_CMD_LEN - 1);
   assign wr_idx = state == IDLE ? 8'd0 : cnt;
   assign o_busy = state != IDLE;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      wr       = 1'b0;
      complete = 1'b0;
      err_inc  = 1'b0;
      if (i_rec_valid) begin
         case (state)
            IDLE: begin
               wr     = 1'b1;
               cnt_nx = 8'd1;
               if (i_rec_last) err_inc = 1'b1;
               else state_nx = len_ok ? RECV : DROP;
            end
            RECV: begin
               wr     = 1'b1;
               cnt_nx = cnt + 8'd1;
               if (i_rec_last) begin
                  state_nx = IDLE;
                  complete = at_end;
                  err_inc  = !at_end;
               end else if (at_end) state_nx = DROP;
            end
            DROP: begin
               err_inc  = i_rec_last;
               state_nx = i_rec_last ? IDLE : DROP;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // The byte arriving with last must reach the outputs, so loads read the merged shadow.
   always_comb begin
      for (int i = 0; i < SH_BYTES; i++)
         sh_nx[i] = (wr && wr_idx == 8'(i)) ? i_rec_data : sh[i];
   end

`ifdef UDP_CMD_CHKSUM_EN
   logic [7:0] x, x_nx;
   assign x_nx   = (wr && wr_idx <= 8'(IDX_CHK)) ? (state == IDLE ? i_rec_data : x ^ i_rec_data) : x;
   assign chk_ok = x_nx == 8'd0;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) x <= '0;
      else x <= x_nx;
   end
`else
   assign chk_ok = 1'b1;
`endif

   assign load     = complete && chk_ok && (!o_cmd_valid || i_cmd_ready);
   assign drop_inc = complete && !load;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         sh          <= '{default: '0};
         o_cmd_op    <= '0;
         o_cmd_ch    <= '0;
         o_cmd_data  <= '0;
         o_cmd_flag  <= '0;
         o_cmd_valid <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         sh          <= sh_nx;
         o_cmd_valid <= load || (o_cmd_valid && !i_cmd_ready);
         if (load) begin
            o_cmd_op   <= sh_nx[IDX_OP];
            o_cmd_ch   <= sh_nx[IDX_CH];
            o_cmd_data <= {sh_nx[IDX_DATA], sh_nx[IDX_DATA+1], sh_nx[IDX_DATA+2], sh_nx[IDX_DATA+3]};
            o_cmd_flag <= sh_nx[IDX_FLAG];
         end
      end
   end

   sat_counter #(.W(P_CNT_W)) u_len_err (
      .clk(i_clk), .rst_n(i_rst_n), .inc(err_inc), .cnt(o_len_err_cnt)
   );
   sat_counter #(.W(P_CNT_W)) u_drop (
      .clk(i_clk), .rst_n(i_rst_n), .inc(drop_inc), .cnt(o_drop_cnt)
   );
endmodule

// File: tb/tb_udp_cmd_rx.sv
// tb_udp_cmd_rx: frame-level reference model with a command scoreboard for udp_cmd_rx
module tb_udp_cmd_rx;
   import udp_cmd_pkg::*;
   localparam int P  = 8;
   localparam int CW = 4;

   typedef struct packed {
      logic [7:0]  op;
      logic [7:0]  ch;
      logic [31:0] data;
      logic [7:0]  flag;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   rec_len;
   logic [7:0]    rec_data;
   logic          rec_last, rec_valid, cmd_ready;
   logic [7:0]    cmd_op, cmd_ch, cmd_flag;
   logic [31:0]   cmd_data;
   logic          cmd_valid, busy;
   logic [CW-1:0] len_err_cnt, drop_cnt;

   always #4 clk = ~clk;

   udp_cmd_rx #(.P_CMD_LEN(P), .P_CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_rec_len(rec_len), .i_rec_data(rec_data),
      .i_rec_last(rec_last), .i_rec_valid(rec_valid), .o_cmd_op(cmd_op), .o_cmd_ch(cmd_ch),
      .o_cmd_data(cmd_data), .o_cmd_flag(cmd_flag), .o_cmd_valid(cmd_valid),
      .i_cmd_ready(cmd_ready), .o_len_err_cnt(len_err_cnt), .o_drop_cnt(drop_cnt), .o_busy(busy)
   );

   cmd_t        exp_q[$];
   logic [7:0]  fb[$];
   logic [7:0]  pay[16];
   logic [15:0] m_len;
   bit          m_inframe, m_held, e_valid, e_busy;
   int          m_err, m_drop, e_err, e_drop;
   int          mode;
   int          tests = 0, fails = 0;

   function automatic int sat(input int v);
      return v >= (1 << CW) - 1 ? v : v + 1;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances by whole-frame rules when a frame ends.
   task automatic beat(input bit v, input logic [7:0] d, input bit l, input logic [15:0] len);
      bit         good, ck, load;
      logic [7:0] x;
      cmd_t       c;
      @(posedge clk);
      #2;
      e_err = m_err; e_drop = m_drop; e_valid = m_held; e_busy = m_inframe;
      cmd_ready = mode == 2 ? 1'($urandom_range(0, 1)) : mode == 3 ? (v && l) : (mode == 1);
      rec_valid = v;
      rec_data  = v ? d : 8'($urandom);
      rec_last  = v ? l : 1'($urandom_range(0, 1));
      rec_len   = v ? len : 16'($urandom);
      load = 1'b0;
      if (v) begin
         if (!m_inframe) begin
            m_len = len;
            fb.delete();
         end
         fb.push_back(d);
         m_inframe = !l;
         if (l) begin
            good = m_len == 16'(P) && fb.size() == P;
            ck = 1'b1;
`ifdef UDP_CMD_CHKSUM_EN
            if (good) begin
               x = 8'd0;
               for (int i = 0; i < 8; i++) x ^= fb[i];
               ck = x == 8'd0;
            end
`endif
            if (!good) m_err = sat(m_err);
            else if (!ck || (m_held && !cmd_ready)) m_drop = sat(m_drop);
            else begin
               c = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5], fb[6]};
               exp_q.push_back(c);
               load = 1'b1;
            end
         end
      end
      m_held = load || (m_held && !cmd_ready);
   endtask

   task automatic idle(input int n);
      repeat (n) beat(0, 8'd0, 0, 16'd0);
   endtask

   task automatic send(input logic [15:0] len, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         if (gap < 0 && i > 0) beat(0, 8'd0, 0, 16'd0);
         while (gap > 0 && $urandom_range(1, 100) <= gap) beat(0, 8'd0, 0, 16'd0);
         beat(1, pay[i], i == n - 1, len);
      end
   endtask

   task automatic set_pay(input logic [63:0] v);
      for (int i = 0; i < 8; i++) pay[i] = v[63-8*i -: 8];
   endtask

   task automatic rand_pay(input bit ok);
      logic [7:0] x;
      x = 8'd0;
      for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
      for (int i = 0; i < 7; i++) x ^= pay[i];
      pay[7] = ok ? x : x ^ 8'($urandom_range(1, 255));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0; rec_valid = 1'b0;
      m_err = 0; m_drop = 0; m_held = 0; m_inframe = 0;
      exp_q.delete();
      e_err = 0; e_drop = 0; e_valid = 0; e_busy = 0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check("valid", cmd_valid, e_valid);
         check("len_err_cnt", len_err_cnt, e_err);
         check("drop_cnt", drop_cnt, e_drop);
         check("busy", busy, e_busy);
         if (!rst_n) check("reset_fields", {cmd_op, cmd_ch, cmd_data, cmd_flag}, 64'd0);
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL cmd actual=%0h required=none at %0t", {cmd_op, cmd_ch, cmd_data, cmd_flag}, $time);
            end else check("cmd", {cmd_op, cmd_ch, cmd_data, cmd_flag}, exp_q.pop_front());
         end
      end
   end

   initial begin
      rec_valid = 0; rec_last = 0; rec_data = 0; rec_len = 0; cmd_ready = 0; mode = 1;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2);
      set_pay({OP_START, 56'h00_01_00_00_00_01_00});
      send(16'd8, 8, 0);
      idle(3);
      set_pay({OP_START, 56'h00_01_00_00_00_01_64});
      send(16'd8, 8, 0);
      idle(3);
      mode = 0;
      send(16'd8, 8, -1);
      idle(5);
      mode = 1;
      idle(3);
      rand_pay(1);
      send(16'd6, 6, 0);
      send(16'd8, 9, 0);
      send(16'd8, 8, 0);
      idle(2);
      mode = 0;
      rand_pay(1);
      send(16'd8, 8, 0);
      rand_pay(1);
      send(16'd8, 8, 0);
      idle(2);
      mode = 1;
      idle(2);
      mode = 0;
      rand_pay(1);
      send(16'd8, 8, 0);
      mode = 3;
      rand_pay(1);
      send(16'd8, 8, 0);
      mode = 1;
      idle(3);
      rand_pay(1);
      for (int i = 0; i < 4; i++) beat(1, pay[i], 0, 16'd8);
      do_reset();
      for (int i = 4; i < 8; i++) beat(1, pay[i], i == 7, 16'd8);
      rand_pay(1);
      send(16'd8, 8, 0);
      idle(2);
      repeat (200) begin
         int len, n;
         mode = $urandom_range(0, 9) < 6 ? 2 : ($urandom_range(0, 1) ? 1 : 3);
         len = $urandom_range(0, 9) < 8 ? 8 : $urandom_range(0, 12);
         n = $urandom_range(0, 9) < 8 ? len : $urandom_range(1, 12);
         if (n < 1) n = 1;
         if (n > 12) n = 12;
         rand_pay($urandom_range(0, 9) < 8);
         send(16'(len), n, $urandom_range(0, 40));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      mode = 1;
      idle(3);
      do_reset();
      repeat (20) begin
         rand_pay(1);
         send(16'd3, 3, 0);
      end
      mode = 0;
      repeat (20) begin
         rand_pay(1);
         send(16'd8, 8, 10);
      end
      mode = 1;
      idle(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/udp_cmd_rx.md
Name: udp_cmd_rx

Overview:
- FPGA-side consumer of the UDP stack receive stream (o_rec_len/data/last/valid), running at 125 MHz in the UDP clock domain.
- Parses fixed-length command packets sent from the PC into a held command word with a valid/ready handshake toward the scope control logic.
- Counterpart of the PC->board command path that the scope-to-PC bench drives.
- The upstream stream has no backpressure, so the block accepts every byte and drops whole frames it cannot deliver.

Parameters:
- P_CMD_LEN, 8, required payload length in bytes (valid range 8..255).
- P_CNT_W, 16, width of the error counters.

Ports:
- i_clk  in  1  UDP stack clock (125 MHz).
- i_rst_n  in  1  asynchronous active-low reset.
- i_rec_len  in  16  payload length, valid on the first beat of a frame.
- i_rec_data  in  8  payload byte.
- i_rec_last  in  1  final byte of the frame.
- i_rec_valid  in  1  byte strobe; may gap mid-frame.
- o_cmd_op  out  8  byte0, opcode.
- o_cmd_ch  out  8  byte1, channel.
- o_cmd_data  out  32  bytes2..5, big-endian (byte2 = MSB).
- o_cmd_flag  out  8  byte6.
- o_cmd_valid  out  1  command held and valid.
- i_cmd_ready  in  1  consumer accepts the command.
- o_len_err_cnt  out  P_CNT_W  frames dropped for length mismatch or early/late last.
- o_drop_cnt  out  P_CNT_W  well-formed frames dropped because the previous command was unaccepted, or (feature on) checksum-failed.
- o_busy  out  1  high while in RECV or DROP.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, byte counter 0. Reset asserted mid-frame abandons the frame. After release, bytes are ignored until the next frame start, which is the first i_rec_valid seen in IDLE.
- States: IDLE, RECV, DROP.
- IDLE, on i_rec_valid:
  - If i_rec_len != P_CMD_LEN: go to DROP; if i_rec_last is also high, count an error and stay in IDLE.
  - Otherwise store byte0, set cnt = 1, go to RECV.
- RECV, each valid byte:
  - Store to the shadow register at index cnt; cnt++.
  - i_rec_last with cnt+1 < P_CMD_LEN (early last): o_len_err_cnt++, go to IDLE.
  - cnt+1 == P_CMD_LEN without last (late last): go to DROP; the count is incremented at last.
  - Last on byte P_CMD_LEN-1: frame complete, go to IDLE.
- Bytes beyond index 7 are received but not decoded (for P_CMD_LEN > 8).
- DROP: discard bytes until i_rec_last, then o_len_err_cnt++ (exactly once per frame) and go to IDLE.
- Frame complete:
  - If o_cmd_valid==0, or o_cmd_valid && i_cmd_ready in the same cycle: the shadow register is copied to the outputs and o_cmd_valid=1 on the next cycle. Latency is 1 cycle from the last byte.
  - Otherwise the frame is discarded, o_drop_cnt++, and the held command is unchanged.
- Handshake:
  - o_cmd_valid stays high and the output fields are stable until i_cmd_ready is sampled high.
  - o_cmd_valid clears the cycle after acceptance unless a new command loads in the same cycle.
- Counters saturate at all-ones with no wrap.
- Back-to-back frames: a new frame may start on the cycle immediately after a last.

Optional Feature:
- Macro UDP_CMD_CHKSUM_EN.
- When defined: byte7 must equal the XOR of bytes 0..6. On mismatch, the complete frame is dropped, o_drop_cnt++, and o_cmd_valid is not raised.
- When undefined: byte7 is ignored.
- Latency is 1 cycle in both builds; the XOR is accumulated on the fly.

Decomposition:
- Package udp_cmd_pkg:
  - state encoding localparams (IDLE/RECV/DROP);
  - byte-index constants IDX_OP=0, IDX_CH=1, IDX_DATA=2..5, IDX_FLAG=6, IDX_CHK=7;
  - opcode constants used by scope control, e.g. OP_START=8'h64.
- Sub-module sat_counter (width-parameterised saturating incrementer), instantiated twice for the error counters.

Test Plan:
- Frame len=8, bytes 100,0,1,0,0,0,1,0 with ready=1 -> next cycle op=100, ch=0, data=32'h01000000, flag=1, valid pulse 1 cycle; counters 0 (feature off).
- Same frame with i_rec_valid gapped every other cycle, and ready held 0 for 5 cycles -> outputs stable, valid high until ready; clears 1 cycle after ready.
- len=6 with 6 bytes and last, then len=8 with 9 bytes (last on byte 9) -> o_len_err_cnt=2, no valid; a following good frame decodes correctly.
- Two good frames back-to-back with ready=0 -> first held, second dropped, o_drop_cnt=1; with ready pulsed on the completion cycle of the second -> second loads, o_drop_cnt unchanged.
- Reset asserted at byte 4 of a frame -> outputs 0; the remaining bytes of that frame are ignored, and the next frame decodes.
- With UDP_CMD_CHKSUM_EN: byte7=100 accepted; byte7=0 -> o_drop_cnt=1, no valid.
